// File: rtl/window_fetch.sv
// Median-filter front end: scans 3x3 windows of a 64x64 image in raster order,
// fetching pixels from image memory and presenting each window over valid/ready.
module window_fetch #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned LAST_IDX = 61
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IDX_W-1:0]   n_col,
  input  logic [IDX_W-1:0]   n_row,
  output logic [IDX_W-1:0]   p_col,
  output logic [IDX_W-1:0]   p_row,
  output logic               mem_rd_en,
  output logic [2*IDX_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]   mem_rd_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*PIX_W-1:0] win_data,
  output logic [IDX_W-1:0]   win_row,
  output logic [IDX_W-1:0]   win_col,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StHold, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(LAST_IDX);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   p_row_q, p_row_d, p_col_q, p_col_d;
  logic [IDX_W-1:0]   win_row_q, win_row_d, win_col_q, win_col_d;
  logic [1:0]         rd_r_q, rd_r_d, rd_c_q, rd_c_d;
  logic               pend_q, pend_d;
  logic [3:0]         pend_slot_q, pend_slot_d;
  logic [PIX_W-1:0]   win_q [9];
  logic [PIX_W-1:0]   win_d [9];
  logic [3:0]         rd_slot;

  assign rd_slot = 4'({2'b00, rd_r_q} * 4'd3) + {2'b00, rd_c_q};

  always_comb begin
    state_d     = state_q;
    p_row_d     = p_row_q;
    p_col_d     = p_col_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    rd_r_d      = rd_r_q;
    rd_c_d      = rd_c_q;
    pend_d      = 1'b0;
    pend_slot_d = pend_slot_q;
    win_d       = win_q;

    // Read data arrives one cycle after its strobe; drop it into the slot it was issued for.
    if (pend_q) begin
      win_d[pend_slot_q] = mem_rd_data;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          p_row_d = '0;
          p_col_d = '0;
          rd_r_d  = 2'd0;
          rd_c_d  = 2'd0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        pend_d      = 1'b1;
        pend_slot_d = rd_slot;
        if (rd_r_q == 2'd2) begin
          rd_r_d = 2'd0;
          rd_c_d = 2'(rd_c_q + 2'd1);
          if (rd_c_q == 2'd2) begin
            state_d = StWait;
          end
        end else begin
          rd_r_d = 2'(rd_r_q + 2'd1);
        end
      end
      StWait: begin
        win_row_d = p_row_q;
        win_col_d = p_col_q;
        state_d   = StHold;
      end
      StHold: begin
        if (win_ready) begin
          if (p_row_q == LastIdx && p_col_q == LastIdx) begin
            state_d = StDone;
          end else begin
            p_row_d = n_row;
            p_col_d = n_col;
            rd_r_d  = 2'd0;
            state_d = StFetch;
            if (n_col == '0) begin
              rd_c_d = 2'd0;
            end else begin
              // Slide: keep the two rightmost columns, only column 2 is refetched.
              rd_c_d = 2'd2;
              for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3+1];
                win_d[r*3 + 1] = win_q[r*3+2];
              end
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      p_row_q     <= '0;
      p_col_q     <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      rd_r_q      <= 2'd0;
      rd_c_q      <= 2'd0;
      pend_q      <= 1'b0;
      pend_slot_q <= 4'd0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      p_row_q     <= p_row_d;
      p_col_q     <= p_col_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      rd_r_q      <= rd_r_d;
      rd_c_q      <= rd_c_d;
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
      win_q       <= win_d;
    end
  end

  always_comb begin
    mem_rd_en = (state_q == StFetch);
    mem_addr  = '0;
    if (mem_rd_en) begin
      mem_addr = {IDX_W'(p_row_q + IDX_W'(rd_r_q)), IDX_W'(p_col_q + IDX_W'(rd_c_q))};
    end
    for (int i = 0; i < 9; i++) begin
      win_data[i*PIX_W +: PIX_W] = win_q[i];
    end
  end

  assign p_row     = p_row_q;
  assign p_col     = p_col_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_window_fetch.sv
// Bench for window_fetch: image memory model, stand-in index counter, and a per-window
// reference built directly from image coordinates.
module tb_window_fetch;

  localparam int PW   = 8;
  localparam int IW   = 6;
  localparam int LAST = 61;

  logic          clk = 1'b0;
  logic          rst_n, start, win_ready;
  logic [IW-1:0] n_col, n_row, p_col, p_row, win_row, win_col;
  logic          mem_rd_en;
  logic [2*IW-1:0] mem_addr;
  logic [PW-1:0] mem_rd_data = '0;
  logic          win_valid, busy, done;
  logic [9*PW-1:0] win_data;

  logic [PW-1:0] img [4096];
  int            tests = 0;
  int            fails = 0;
  int            done_cnt = 0;
  int            rd_q[$];

  window_fetch #(.PIX_W(PW), .IDX_W(IW), .LAST_IDX(LAST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_col(n_col), .n_row(n_row),
    .p_col(p_col), .p_row(p_row), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Raster-order successor of the current position.
  always_comb begin
    if (p_col == 6'(LAST)) begin
      n_col = '0;
      n_row = 6'(p_row + 6'd1);
    end else begin
      n_col = 6'(p_col + 6'd1);
      n_row = p_row;
    end
  end

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= img[mem_addr];

  always @(negedge clk) begin
    if (mem_rd_en) rd_q.push_back(32'(mem_addr));
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [9*PW-1:0] exp_win(input int r, input int c);
    logic [9*PW-1:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*PW +: PW] = img[(r+i)*64 + c + j];
    return w;
  endfunction

  // Wait for the window after a trigger (start or handshake), check it, stall, then accept.
  task automatic do_window(input int er, input int ec, input int stall);
    int cyc;
    int exp_rd[$];
    logic [9*PW-1:0] w;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!win_valid && cyc < 40);
    check("latency", 128'(cyc), 128'((ec == 0) ? 11 : 5));
    w = exp_win(er, ec);
    check("win_data", win_data, w);
    check("win_row", win_row, 128'(er));
    check("win_col", win_col, 128'(ec));
    check("p_pos", {p_row, p_col}, {6'(er), 6'(ec)});
    if (ec == 0) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++) exp_rd.push_back((er + r) * 64 + c);
    end else begin
      for (int r = 0; r < 3; r++) exp_rd.push_back((er + r) * 64 + ec + 2);
    end
    check("rd_count", 128'(rd_q.size()), 128'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      check("rd_addr", 128'(rd_q[i]), 128'(exp_rd[i]));
    win_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 128'(win_valid), 128'(1));
      check("stall_data", win_data, w);
      check("stall_rd_en", 128'(mem_rd_en), 128'(0));
      check("stall_pos", {p_row, p_col}, {6'(er), 6'(ec)});
    end
    win_ready = 1'b1;
    rd_q.delete();
  endtask

  initial begin
    int stall;
    for (int i = 0; i < 4096; i++) img[i] = 8'(((i / 64) * 7 + (i % 64)) & 255);
    rst_n = 1'b0;
    start = 1'b0;
    win_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {p_row, p_col, win_row, win_col, mem_addr, mem_rd_en, win_valid,
                         busy, done, win_data}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 128'(busy), 128'(0));

    // Full frame, random back-pressure; a start mid-scan must be ignored.
    rd_q.delete();
    start = 1'b1;
    for (int r = 0; r <= LAST; r++) begin
      for (int c = 0; c <= LAST; c++) begin
        if (r == 0 && c < 2) stall = 0;
        else if (r == 0 && c == 2) stall = 20;
        else stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        do_window(r, c, stall);
        if (r == 20 && c == 30) start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", {done, busy, win_valid}, 3'b110);
    @(negedge clk);
    check("after_done", {done, busy}, 2'b00);
    repeat (3) @(negedge clk);
    check("done_count", 128'(done_cnt), 128'(1));
    check("idle_rd_en", 128'(mem_rd_en), 128'(0));

    // Second frame on random image, aborted by reset while fetching window (5,9).
    for (int i = 0; i < 4096; i++) img[i] = 8'($urandom);
    rd_q.delete();
    start = 1'b1;
    for (int k = 0; k < 5 * 62 + 9; k++) do_window(k / 62, k % 62, 0);
    @(negedge clk);
    check("fetch_5_9", {mem_rd_en, p_row, p_col}, {1'b1, 6'd5, 6'd9});
    rst_n = 1'b0;
    @(negedge clk);
    check("midscan_reset", {p_row, p_col, win_row, win_col, mem_addr, mem_rd_en, win_valid,
                            busy, done, win_data}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_win_after_reset", 128'(win_valid), 128'(0));
    rd_q.delete();
    start = 1'b1;
    do_window(0, 0, 0);
    do_window(0, 1, 0);
    check("done_count_final", 128'(done_cnt), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
